// File: rtl/led_scan.sv
// led_scan -- LED pattern sequencer driven by a programmable prescaler.
//
// A DIV_W-bit prescaler counts clocks up to a SPEED-dependent threshold.
// Each time it reaches that threshold, TICK pulses for one clock and the
// pattern takes one step. The available patterns are bounce, rotate left,
// rotate right and blink-all. Changing MODE restarts the chosen pattern
// from its first position.
//
// Parameters
//   NLED   number of LED outputs (2..16)
//   DIV_W  prescaler width; base step period is 2^DIV_W clocks (4..32)
//
// Ports
//   CLK    input            system clock, rising edge
//   RST    input            synchronous active-high reset
//   MODE   input  [1:0]     00 bounce, 01 rotate left, 10 rotate right, 11 blink
//   SPEED  input  [1:0]     step period = 2^(DIV_W-SPEED) clocks
//   PAUSE  input            freezes prescaler and pattern state
//   LED    output [NLED-1:0] LED drive, bit 0 = rightmost
//   TICK   output           one-clock pulse in the cycle a step is taken
module led_scan #(
    parameter int NLED  = 4,
    parameter int DIV_W = 23
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [1:0]      MODE,
    input  logic [1:0]      SPEED,
    input  logic            PAUSE,
    output logic [NLED-1:0] LED,
    output logic            TICK
);

    localparam int POS_W = (NLED > 1) ? $clog2(NLED) : 1;

    localparam logic [POS_W-1:0] POS_LAST = POS_W'(NLED - 1);
    localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);
    localparam logic [DIV_W-1:0] CNT_ONE  = DIV_W'(1);

    typedef enum logic [1:0] {
        M_BOUNCE = 2'b00,
        M_ROTL   = 2'b01,
        M_ROTR   = 2'b10,
        M_BLINK  = 2'b11
    } mode_e;

    mode_e            mode_q, mode_d;
    logic [DIV_W-1:0] cnt_q,  cnt_d;
    logic [POS_W-1:0] pos_q,  pos_d;
    logic             dir_q,  dir_d;
    logic             ph_q,   ph_d;
    logic             tick_d;
    logic [DIV_W-1:0] thr;
    logic             mode_chg;

    // Shifting an all-ones word right by SPEED gives 2^(DIV_W-SPEED)-1
    // without ever needing a wider intermediate.
    assign thr      = {DIV_W{1'b1}} >> SPEED;
    assign mode_chg = (MODE != mode_q);

    always_comb begin
        mode_d = mode_q;
        cnt_d  = cnt_q;
        pos_d  = pos_q;
        dir_d  = dir_q;
        ph_d   = ph_q;
        tick_d = 1'b0;

        if (mode_chg) begin
            // A restart wins over any coincident tick, and PAUSE does not block it.
            mode_d = mode_e'(MODE);
            cnt_d  = '0;
            pos_d  = '0;
            dir_d  = 1'b0;
            ph_d   = 1'b0;
        end else if (!PAUSE) begin
            // Using >= here lets a sudden SPEED increase tick at once.
            // Otherwise the counter would wrap through 2^DIV_W first.
            if (cnt_q >= thr) begin
                tick_d = 1'b1;
                cnt_d  = '0;
                unique case (mode_q)
                    M_BOUNCE: begin
                        if (!dir_q) begin
                            if (pos_q == POS_LAST) begin
                                dir_d = 1'b1;
                                pos_d = pos_q - POS_ONE;
                            end else begin
                                pos_d = pos_q + POS_ONE;
                            end
                        end else begin
                            if (pos_q == '0) begin
                                dir_d = 1'b0;
                                pos_d = pos_q + POS_ONE;
                            end else begin
                                pos_d = pos_q - POS_ONE;
                            end
                        end
                    end
                    M_ROTL:  pos_d = (pos_q == POS_LAST) ? '0 : pos_q + POS_ONE;
                    M_ROTR:  pos_d = (pos_q == '0) ? POS_LAST : pos_q - POS_ONE;
                    M_BLINK: ph_d  = ~ph_q;
                    default: ;
                endcase
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            mode_q <= M_BOUNCE;
            cnt_q  <= '0;
            pos_q  <= '0;
            dir_q  <= 1'b0;
            ph_q   <= 1'b0;
        end else begin
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            pos_q  <= pos_d;
            dir_q  <= dir_d;
            ph_q   <= ph_d;
        end
    end

    assign TICK = tick_d & ~RST;

    // LED is decoded only from registered state, so a step shows up the
    // cycle after its TICK.
    always_comb begin
        if (mode_q == M_BLINK) begin
            LED = {NLED{ph_q}};
        end else begin
            LED = {{(NLED-1){1'b0}}, 1'b1} << pos_q;
        end
    end

endmodule

// File: tb/tb_led_scan.sv
// Scoreboard bench for led_scan. Two instances share the same stimulus:
// one with NLED=4 and one with NLED=2, both using DIV_W=4. The reference
// model tracks only the mode, the number of steps taken since the pattern
// restarted, and the prescaler count. It derives each LED image from
// that step count arithmetically.
module tb_led_scan;

    localparam int DIV_W = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic [1:0]  MODE;
    logic [1:0]  SPEED;
    logic        PAUSE;
    logic [3:0]  led_a;
    logic        tick_a;
    logic [1:0]  led_b;
    logic        tick_b;

    always #5 CLK = ~CLK;

    led_scan #(.NLED(4), .DIV_W(DIV_W)) dut_a (
        .CLK(CLK), .RST(RST), .MODE(MODE), .SPEED(SPEED), .PAUSE(PAUSE),
        .LED(led_a), .TICK(tick_a)
    );

    led_scan #(.NLED(2), .DIV_W(DIV_W)) dut_b (
        .CLK(CLK), .RST(RST), .MODE(MODE), .SPEED(SPEED), .PAUSE(PAUSE),
        .LED(led_b), .TICK(tick_b)
    );

    typedef struct {
        logic [15:0] led0;
        logic        tick0;
        logic [15:0] led1;
        logic        tick1;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    // Reference state, index 0 -> NLED=4, index 1 -> NLED=2
    int nled [2] = '{4, 2};
    int m_mode [2];
    int m_steps[2];
    int m_cnt  [2];

    function automatic logic [15:0] exp_led(int n, int mode, int k);
        int per;
        int p;
        logic [15:0] all;
        all = 16'((32'd1 << n) - 1);
        case (mode)
            0: begin
                per = 2 * (n - 1);
                p = k % per;
                if (p >= n) p = per - p;
                return 16'(32'd1 << p);
            end
            1: return 16'(32'd1 << (k % n));
            2: return 16'(32'd1 << ((n - (k % n)) % n));
            default: return (k % 2 == 1) ? all : 16'd0;
        endcase
    endfunction

    function automatic int thr_of(int spd);
        return (1 << (DIV_W - spd)) - 1;
    endfunction

    function automatic logic exp_tick(int i);
        return !RST && (int'(MODE) == m_mode[i]) && !PAUSE &&
               (m_cnt[i] >= thr_of(int'(SPEED)));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0; m_steps[i] = 0; m_cnt[i] = 0;
        end
    endtask

    // Advance the model across one rising edge using the inputs that were
    // applied during the cycle before it.
    task automatic model_edge(logic rst, logic [1:0] mode, logic [1:0] spd, logic pause);
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_mode[i] = 0; m_steps[i] = 0; m_cnt[i] = 0;
            end else if (int'(mode) != m_mode[i]) begin
                m_mode[i] = int'(mode); m_steps[i] = 0; m_cnt[i] = 0;
            end else if (!pause) begin
                if (m_cnt[i] >= thr_of(int'(spd))) begin
                    m_steps[i]++;
                    m_cnt[i] = 0;
                end else begin
                    m_cnt[i]++;
                end
            end
        end
    endtask

    task automatic push_expected();
        exp_t e;
        e.led0  = exp_led(nled[0], m_mode[0], m_steps[0]);
        e.tick0 = exp_tick(0);
        e.led1  = exp_led(nled[1], m_mode[1], m_steps[1]);
        e.tick1 = exp_tick(1);
        exp_q.push_back(e);
    endtask

    task automatic check(string name, logic [15:0] act, logic [15:0] req);
        checks++;
        if (act === req) begin
            passed++;
        end else begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
        end
    endtask

    // Monitor: every cycle the DUTs present an LED image and a TICK level.
    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("led_n4",  {12'd0, led_a},  e.led0);
            check("tick_n4", {15'd0, tick_a}, {15'd0, e.tick0});
            check("led_n2",  {14'd0, led_b},  e.led1);
            check("tick_n2", {15'd0, tick_b}, {15'd0, e.tick1});
        end
    end

    task automatic cycle();
        logic r;
        logic [1:0] m;
        logic [1:0] s;
        logic p;
        push_expected();
        r = RST; m = MODE; s = SPEED; p = PAUSE;
        @(posedge CLK);
        #1;
        model_edge(r, m, s, p);
    endtask

    initial begin
        RST = 1'b1; MODE = 2'b00; SPEED = 2'b00; PAUSE = 1'b0;
        @(posedge CLK);
        #1;
        model_reset();

        // The reset cycle itself must show TICK low.
        cycle();
        RST = 1'b0;

        // Plain bounce at the slowest speed.
        repeat (120) cycle();

        // Pause long enough to cover a full step period, then resume.
        PAUSE = 1'b1;
        repeat (40) cycle();
        PAUSE = 1'b0;
        repeat (30) cycle();

        // Run each mode in turn at several speeds.
        for (int md = 1; md < 4; md++) begin
            MODE = 2'(md);
            for (int sp = 0; sp < 4; sp++) begin
                SPEED = 2'(sp);
                repeat (45) cycle();
            end
        end

        // Randomized traffic.
        MODE = 2'b00; SPEED = 2'b00;
        for (int c = 0; c < 6000; c++) begin
            if ($urandom_range(79) == 0) MODE = 2'($urandom_range(3));
            if ($urandom_range(49) == 0) SPEED = 2'($urandom_range(3));
            if (PAUSE) begin
                if ($urandom_range(19) == 0) PAUSE = 1'b0;
            end else begin
                if ($urandom_range(59) == 0) PAUSE = 1'b1;
            end
            RST = ($urandom_range(299) == 0);
            cycle();
        end
        RST = 1'b0;

        repeat (3) @(negedge CLK);
        checks++;
        if (exp_q.size() == 0) begin
            passed++;
        end else begin
            fails++;
            $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
